// File: rtl/mem_responder.sv
// Memory-side responder for the CPU fetch and load/store ports: word RAM plus a small MMIO window.
// Define MEM_RESPONDER_PERF_EN to add FETCHES/LOADS/STORES counters at MMIO offsets +6/+8/+10.
module mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [15:0] MMIO_BASE   = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_pc_addr,
    input  logic        i_pc_rd,
    output logic [15:0] o_pc_rddata,
    input  logic [15:0] i_ldst_addr,
    input  logic        i_ldst_rd,
    input  logic        i_ldst_wr,
    input  logic [15:0] i_ldst_wrdata,
    output logic [15:0] o_ldst_rddata,
    output logic [15:0] o_leds,
    output logic        o_err
);
    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH_WORDS);
    localparam logic [16:0] MMIO_LO = {1'b0, MMIO_BASE};
    localparam logic [16:0] MMIO_HI = {1'b0, MMIO_BASE} + 17'd15;

    localparam logic [2:0] REG_CYCLE  = 3'd0;
    localparam logic [2:0] REG_LEDS   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
`ifdef MEM_RESPONDER_PERF_EN
    localparam logic [2:0] REG_FETCHES = 3'd3;
    localparam logic [2:0] REG_LOADS   = 3'd4;
    localparam logic [2:0] REG_STORES  = 3'd5;
`endif

    logic [15:0]   ram [DEPTH_WORDS];
    logic [15:0]   cycle_cnt;
    logic [15:0]   leds;
    logic          err;

    logic          pc_mmio;
    logic          pc_ram;
    logic          ldst_mmio;
    logic          ldst_ram;
    logic [AW-1:0] pc_idx;
    logic [AW-1:0] ldst_idx;
    logic [3:0]    ldst_off;
    logic [2:0]    ldst_reg;
    logic          ram_wr;
    logic          mmio_wr;
    logic          pc_hit;
    logic          err_set;
    logic          err_clr;
    logic [15:0]   mmio_rdata;

`ifdef MEM_RESPONDER_PERF_EN
    logic [15:0]   fetch_cnt;
    logic [15:0]   load_cnt;
    logic [15:0]   store_cnt;
`endif

    // Address decode: the MMIO window wins over RAM; anything else is unmapped.
    always_comb begin
        pc_mmio   = ({1'b0, i_pc_addr} >= MMIO_LO) && ({1'b0, i_pc_addr} <= MMIO_HI);
        ldst_mmio = ({1'b0, i_ldst_addr} >= MMIO_LO) && ({1'b0, i_ldst_addr} <= MMIO_HI);
        pc_ram    = !pc_mmio && ({1'b0, i_pc_addr[15:1]} < DEPTH16);
        ldst_ram  = !ldst_mmio && ({1'b0, i_ldst_addr[15:1]} < DEPTH16);
        pc_idx    = i_pc_addr[AW:1];
        ldst_idx  = i_ldst_addr[AW:1];
        ldst_off  = i_ldst_addr[3:0] - MMIO_BASE[3:0];
        ldst_reg  = 3'(ldst_off >> 1);
        ram_wr    = i_ldst_wr && ldst_ram;
        mmio_wr   = i_ldst_wr && ldst_mmio;
        pc_hit    = ram_wr && pc_ram && (pc_idx == ldst_idx);
        err_set   = (i_pc_rd && !pc_ram)
                  || ((i_ldst_rd || i_ldst_wr) && !ldst_mmio && !ldst_ram);
        err_clr   = mmio_wr && (ldst_reg == REG_STATUS) && i_ldst_wrdata[0];
    end

    always_comb begin
        mmio_rdata = '0;
        case (ldst_reg)
            REG_CYCLE:   mmio_rdata = cycle_cnt;
            REG_LEDS:    mmio_rdata = i_ldst_wr ? i_ldst_wrdata : leds;
            REG_STATUS:  mmio_rdata = {15'd0, err};
`ifdef MEM_RESPONDER_PERF_EN
            REG_FETCHES: mmio_rdata = fetch_cnt;
            REG_LOADS:   mmio_rdata = load_cnt;
            REG_STORES:  mmio_rdata = store_cnt;
`endif
            default:     mmio_rdata = '0;
        endcase
    end

    // RAM contents survive reset; only the write is gated.
    always_ff @(posedge clk) begin
        if (reset && ram_wr) begin
            ram[ldst_idx] <= i_ldst_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            o_pc_rddata   <= '0;
            o_ldst_rddata <= '0;
            leds          <= '0;
            err           <= 1'b0;
            cycle_cnt     <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (i_pc_rd) begin
                o_pc_rddata <= !pc_ram ? 16'h0000 : (pc_hit ? i_ldst_wrdata : ram[pc_idx]);
            end
            if (i_ldst_rd) begin
                if (ldst_mmio) begin
                    o_ldst_rddata <= mmio_rdata;
                end else if (!ldst_ram) begin
                    o_ldst_rddata <= 16'h0000;
                end else begin
                    o_ldst_rddata <= ram_wr ? i_ldst_wrdata : ram[ldst_idx];
                end
            end
            if (mmio_wr && (ldst_reg == REG_LEDS)) begin
                leds <= i_ldst_wrdata;
            end
            if (err_clr) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

`ifdef MEM_RESPONDER_PERF_EN
    // A write to a counter's offset clears it, even if an access counts in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            fetch_cnt <= (mmio_wr && (ldst_reg == REG_FETCHES)) ? 16'h0000 : fetch_cnt + 16'(i_pc_rd);
            load_cnt  <= (mmio_wr && (ldst_reg == REG_LOADS))   ? 16'h0000 : load_cnt + 16'(i_ldst_rd);
            store_cnt <= (mmio_wr && (ldst_reg == REG_STORES))  ? 16'h0000 : store_cnt + 16'(i_ldst_wr);
        end
    end
`endif

    assign o_leds = leds;
    assign o_err  = err;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// compared every cycle against a behavioural memory/MMIO model.
module tb_mem_responder;
    localparam int          DEPTH = 4096;
    localparam logic [15:0] BASE  = 16'hF000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_addr;
    logic        pc_rd;
    logic [15:0] pc_rddata;
    logic [15:0] ldst_addr;
    logic        ldst_rd;
    logic        ldst_wr;
    logic [15:0] ldst_wrdata;
    logic [15:0] ldst_rddata;
    logic [15:0] leds;
    logic        err;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pc_addr     (pc_addr),
        .i_pc_rd       (pc_rd),
        .o_pc_rddata   (pc_rddata),
        .i_ldst_addr   (ldst_addr),
        .i_ldst_rd     (ldst_rd),
        .i_ldst_wr     (ldst_wr),
        .i_ldst_wrdata (ldst_wrdata),
        .o_ldst_rddata (ldst_rddata),
        .o_leds        (leds),
        .o_err         (err)
    );

    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] m_pc;
    logic [15:0] m_ld;
    bit          m_pc_care;
    bit          m_ld_care;
    logic [15:0] m_leds;
    logic        m_err;
    int unsigned m_cycle;
    int unsigned m_fetches;
    int unsigned m_loads;
    int unsigned m_stores;
    bit          m_valid = 1'b0;

    int checks = 0;
    int passes = 0;

    // 0 = RAM, 1 = MMIO, 2 = unmapped
    function automatic int region(input logic [15:0] a);
        if (int'(a) >= int'(BASE) && int'(a) <= int'(BASE) + 15) return 1;
        if (int'(a) / 2 < DEPTH) return 0;
        return 2;
    endfunction

    function automatic logic [15:0] mmioRead(input int off);
        case (off)
            0: return 16'(m_cycle);
            1: return ldst_wr ? ldst_wrdata : m_leds;
            2: return {15'd0, m_err};
`ifdef MEM_RESPONDER_PERF_EN
            3: return 16'(m_fetches);
            4: return 16'(m_loads);
            5: return 16'(m_stores);
`endif
            default: return 16'h0000;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic modelEdge();
        int pr, lr, pw, lw, off;
        bit set, clr;
        if (!reset) begin
            m_pc = 0; m_ld = 0; m_pc_care = 1; m_ld_care = 1;
            m_leds = 0; m_err = 0; m_cycle = 0;
            m_fetches = 0; m_loads = 0; m_stores = 0;
            m_valid = 1;
            return;
        end
        pr = region(pc_addr);
        lr = region(ldst_addr);
        pw = int'(pc_addr) / 2;
        lw = int'(ldst_addr) / 2;
        off = (int'(ldst_addr) - int'(BASE)) / 2;
        set = 0;
        clr = 0;
        if (pc_rd) begin
            m_pc_care = 1;
            if (pr != 0) begin
                m_pc = 0; set = 1;
            end else if (ldst_wr && lr == 0 && lw == pw) begin
                m_pc = ldst_wrdata;
            end else begin
                m_pc = m_mem[pw]; m_pc_care = m_known[pw];
            end
        end
        if (ldst_rd) begin
            m_ld_care = 1;
            if (lr == 2) begin
                m_ld = 0; set = 1;
            end else if (lr == 1) begin
                m_ld = mmioRead(off);
            end else if (ldst_wr) begin
                m_ld = ldst_wrdata;
            end else begin
                m_ld = m_mem[lw]; m_ld_care = m_known[lw];
            end
        end
        if (ldst_wr) begin
            if (lr == 0) begin
                m_mem[lw] = ldst_wrdata; m_known[lw] = 1;
            end else if (lr == 2) begin
                set = 1;
            end else if (off == 1) begin
                m_leds = ldst_wrdata;
            end else if (off == 2) begin
                clr = ldst_wrdata[0];
            end
        end
`ifdef MEM_RESPONDER_PERF_EN
        if (ldst_wr && lr == 1 && off == 3) m_fetches = 0; else if (pc_rd) m_fetches++;
        if (ldst_wr && lr == 1 && off == 4) m_loads = 0;   else if (ldst_rd) m_loads++;
        if (ldst_wr && lr == 1 && off == 5) m_stores = 0;  else if (ldst_wr) m_stores++;
`endif
        if (clr) m_err = 0;
        else if (set) m_err = 1;
        m_cycle++;
    endtask

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    task automatic checkOutput();
        if (!m_valid) return;
        if (m_pc_care) checkValue("pc_rddata", pc_rddata, m_pc);
        if (m_ld_care) checkValue("ldst_rddata", ldst_rddata, m_ld);
        checkValue("leds", leds, m_leds);
        checkValue("err", {15'd0, err}, {15'd0, m_err});
    endtask

    task automatic applyStimulus(input logic rst, input logic prd, input logic [15:0] paddr,
                                 input logic lrd, input logic lwr, input logic [15:0] laddr,
                                 input logic [15:0] wdata);
        reset = rst; pc_rd = prd; pc_addr = paddr;
        ldst_rd = lrd; ldst_wr = lwr; ldst_addr = laddr; ldst_wrdata = wdata;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    endtask

    function automatic logic [15:0] randAddr();
        int r;
        r = int'($urandom_range(9));
        if (r <= 5) return 16'($urandom_range(63));
        if (r <= 7) return BASE + 16'($urandom_range(15));
        if (r == 8) return 16'h2000 + 16'($urandom_range(16'hCFFF));
        return 16'h1FFE + 16'($urandom_range(3));
    endfunction

    logic [15:0] c1;
    logic [15:0] c2;

    initial begin
        $display("[TB] mem_responder bench starting");
        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 1, 16'h0010, 1, 1, 16'h0010, 16'h1111);
        checkValue("reset_pc", pc_rddata, 16'h0000);
        checkValue("reset_ld", ldst_rddata, 16'h0000);
        checkValue("reset_leds", leds, 16'h0000);
        checkValue("reset_err", {15'd0, err}, 16'h0000);

        applyStimulus(1, 0, 16'h0000, 0, 1, 16'h0010, 16'hBEEF);
        applyStimulus(1, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000);
        checkValue("load_beef", ldst_rddata, 16'hBEEF);

        applyStimulus(1, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
        checkValue("fetch_beef", pc_rddata, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkValue("fetch_hold", pc_rddata, 16'hBEEF);
        end

        applyStimulus(1, 1, 16'h0020, 0, 1, 16'h0020, 16'h1234);
        checkValue("collide_pc", pc_rddata, 16'h1234);
        applyStimulus(1, 0, 16'h0000, 1, 1, 16'h0030, 16'h5678);
        checkValue("rdwr_ld", ldst_rddata, 16'h5678);

        applyStimulus(1, 0, 16'h0000, 0, 1, BASE + 16'd2, 16'h00A5);
        checkValue("leds_a5", leds, 16'h00A5);
        applyStimulus(1, 0, 16'h0000, 1, 0, BASE, 16'h0000);
        c1 = ldst_rddata;
        for (int i = 0; i < 4; i++) idle();
        applyStimulus(1, 0, 16'h0000, 1, 0, BASE, 16'h0000);
        c2 = ldst_rddata;
        checkValue("cycle_delta", c2 - c1, 16'd5);

        applyStimulus(1, 0, 16'h0000, 1, 0, 16'hE000, 16'h0000);
        checkValue("unmapped_rd", ldst_rddata, 16'h0000);
        checkValue("unmapped_err", {15'd0, err}, 16'h0001);
        applyStimulus(1, 0, 16'h0000, 0, 1, BASE + 16'd4, 16'h0001);
        checkValue("err_clear", {15'd0, err}, 16'h0000);
        applyStimulus(1, 1, BASE, 0, 0, 16'h0000, 16'h0000);
        checkValue("pc_mmio_rd", pc_rddata, 16'h0000);
        checkValue("pc_mmio_err", {15'd0, err}, 16'h0001);

        // Reset aborting in-flight accesses; the write during reset must not land.
        applyStimulus(1, 1, 16'h0010, 1, 0, 16'h0010, 16'h0000);
        applyStimulus(0, 1, 16'h0010, 1, 1, 16'h0010, 16'hDEAD);
        checkValue("abort_pc", pc_rddata, 16'h0000);
        checkValue("abort_ld", ldst_rddata, 16'h0000);
        idle();
        checkValue("abort_hold", ldst_rddata, 16'h0000);
        applyStimulus(1, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000);
        checkValue("ram_kept", ldst_rddata, 16'hBEEF);

        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000);
        applyStimulus(1, 0, 16'h0000, 0, 1, 16'h0040, 16'h0000);
        applyStimulus(1, 0, 16'h0000, 1, 0, BASE + 16'd8, 16'h0000);
`ifdef MEM_RESPONDER_PERF_EN
        checkValue("perf_loads", ldst_rddata, 16'd2);
`else
        checkValue("perf_loads_off", ldst_rddata, 16'd0);
`endif
        applyStimulus(1, 0, 16'h0000, 1, 0, BASE + 16'd6, 16'h0000);
`ifdef MEM_RESPONDER_PERF_EN
        checkValue("perf_fetches", ldst_rddata, 16'd3);
`else
        checkValue("perf_fetches_off", ldst_rddata, 16'd0);
`endif
        applyStimulus(1, 0, 16'h0000, 1, 0, BASE + 16'd10, 16'h0000);
`ifdef MEM_RESPONDER_PERF_EN
        checkValue("perf_stores", ldst_rddata, 16'd1);
`else
        checkValue("perf_stores_off", ldst_rddata, 16'd0);
`endif

        // Counter wrap: after reset, 65535 idle edges leave CYCLE at FFFF.
        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 65535; i++) idle();
        applyStimulus(1, 0, 16'h0000, 1, 0, BASE, 16'h0000);
        checkValue("cycle_ffff", ldst_rddata, 16'hFFFF);
        applyStimulus(1, 0, 16'h0000, 1, 0, BASE, 16'h0000);
        checkValue("cycle_wrap", ldst_rddata, 16'h0000);

        for (int i = 0; i < 2000; i++) begin
            logic        r_rst, r_prd, r_lrd, r_lwr;
            logic [15:0] r_pa, r_la;
            r_rst = ($urandom_range(99) != 0);
            r_prd = 1'($urandom_range(1));
            r_lrd = 1'($urandom_range(1));
            r_lwr = ($urandom_range(2) == 0);
            r_pa  = randAddr();
            r_la  = randAddr();
            if (r_lwr && r_lrd && region(r_la) == 1 && (int'(r_la) - int'(BASE)) / 2 != 1) r_lrd = 0;
            applyStimulus(r_rst, r_prd, r_pa, r_lrd, r_lwr, r_la, 16'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
